fifo_read_arbiter: RTL and testbench

Read-side arbiter for the asynchronous dual-clock FIFO. It shares the single FIFO read port between NREQ consumers in the read clock domain. It grants one consumer at a time in round-robin order, bounds each grant to a burst of BURST words, and drives the FIFO's rinc from the granted consumer's take strobe, gated by rempty. It sits between the FIFO read-pointer/empty logic and the consumers, which all see the shared rdata bus.

---
 rtl/fifo_read_arbiter.sv | 132 +++++++++++++
 tb/tb_fifo_read_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_arbiter.sv
// fifo_read_arbiter: shares the async FIFO read port between NREQ consumers.
// Round-robin grant, each grant limited to BURST pops, released early when the
// grantee drops req or the FIFO stays empty for TIMEOUT consecutive cycles.
// rinc_o is combinational from the registered grant, so reset kills it at once.
module fifo_read_arbiter #(
  parameter int NREQ    = 4,
  parameter int BURST   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic            rclk_i,
  input  logic            rrst_i,
  input  logic [NREQ-1:0] req_i,
  input  logic [NREQ-1:0] take_i,
  input  logic            rempty_i,
  output logic            rinc_o,
  output logic [NREQ-1:0] gnt_o,
  output logic [2:0]      gnt_id_o,
  output logic            busy_o,
  output logic [3:0]      burst_cnt_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [2:0]      gnt_id_q, gnt_id_d;
  logic [3:0]      burst_cnt_q, burst_cnt_d;
  logic [3:0]      empty_cnt_q, empty_cnt_d;
  logic [2:0]      rr_ptr_q, rr_ptr_d;

  logic            pick_found;
  logic [2:0]      pick_idx;
  logic            req_g;
  logic            pop;
  logic            release_grant;

  // The grant register is zero in IDLE, so no pop can escape outside GRANT.
  assign req_g  = |(gnt_q & req_i);
  assign pop    = |(gnt_q & req_i & take_i) & ~rempty_i;
  assign rinc_o = pop;

  assign gnt_o       = gnt_q;
  assign gnt_id_o    = gnt_id_q;
  assign busy_o      = (state_q == GRANT);
  assign burst_cnt_o = burst_cnt_q;

  // Round-robin pick: first requester at or above rr_ptr, wrapping; the
  // descending scan lets the closest candidate overwrite farther ones.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = 3'd0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      int c;
      c = int'(rr_ptr_q) + k;
      if (c >= NREQ) c = c - NREQ;
      if (req_i[c]) begin
        pick_found = 1'b1;
        pick_idx   = 3'(c);
      end
    end
  end

  // Release priority: req drop, last word of the burst, empty timeout.
  always_comb begin
    release_grant = 1'b0;
    if (!req_g) begin
      release_grant = 1'b1;
    end else if (pop && (burst_cnt_q == 4'(BURST - 1))) begin
      release_grant = 1'b1;
    end else if (rempty_i && (empty_cnt_q == 4'(TIMEOUT - 1))) begin
      release_grant = 1'b1;
    end
  end

  // Next-state and register updates for the two-state grant FSM.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    burst_cnt_d = burst_cnt_q;
    empty_cnt_d = empty_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (pick_found && !rempty_i) begin
          state_d     = GRANT;
          gnt_d       = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
          gnt_id_d    = pick_idx;
          burst_cnt_d = 4'd0;
          empty_cnt_d = 4'd0;
        end
      end
      GRANT: begin
        if (pop) burst_cnt_d = burst_cnt_q + 4'd1;
        empty_cnt_d = rempty_i ? (empty_cnt_q + 4'd1) : 4'd0;
        if (release_grant) begin
          state_d  = IDLE;
          gnt_d    = '0;
          rr_ptr_d = (gnt_id_q == 3'(NREQ - 1)) ? 3'd0 : (gnt_id_q + 3'd1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge rclk_i or posedge rrst_i) begin
    if (rrst_i) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_id_q    <= 3'd0;
      burst_cnt_q <= 4'd0;
      empty_cnt_q <= 4'd0;
      rr_ptr_q    <= 3'd0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      burst_cnt_q <= burst_cnt_d;
      empty_cnt_q <= empty_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Testbench for fifo_read_arbiter: directed scenarios then random traffic,
// checked against a behavioural model of the grant rules and a FIFO level.
module tb_fifo_read_arbiter;

  localparam int N = 4;
  localparam int B = 4;
  localparam int T = 8;

  logic         rclk = 1'b0;
  logic         rrst;
  logic [N-1:0] req;
  logic [N-1:0] take;
  logic         rempty;
  logic         rinc;
  logic [N-1:0] gnt;
  logic [2:0]   gnt_id;
  logic         busy;
  logic [3:0]   burst_cnt;

  fifo_read_arbiter #(.NREQ(N), .BURST(B), .TIMEOUT(T)) dut (
    .rclk_i      (rclk),
    .rrst_i      (rrst),
    .req_i       (req),
    .take_i      (take),
    .rempty_i    (rempty),
    .rinc_o      (rinc),
    .gnt_o       (gnt),
    .gnt_id_o    (gnt_id),
    .busy_o      (busy),
    .burst_cnt_o (burst_cnt)
  );

  always #5 rclk = ~rclk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: owner = -1 when nobody holds the port.
  int m_owner, m_pops, m_empties, m_rr, m_last;
  int level;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_pop();
    return (m_owner >= 0) && req[m_owner] && take[m_owner] && !rempty;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_pops = 0; m_empties = 0; m_rr = 0; m_last = 0;
  endtask

  task automatic model_edge();
    bit p;
    bit found;
    p = exp_pop();
    if (m_owner < 0) begin
      if (req != 0 && !rempty) begin
        found = 0;
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_rr + k) % N;
          if (!found && req[c]) begin
            found = 1;
            m_owner = c;
          end
        end
        m_pops = 0; m_empties = 0; m_last = m_owner;
      end
    end else begin
      bit drop;
      drop = !req[m_owner];
      if (p) m_pops++;
      if (rempty) m_empties++; else m_empties = 0;
      if (drop || (p && m_pops == B) || (m_empties == T)) begin
        m_rr = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
  endtask

  // One clock: check rinc before the edge, registered outputs after it.
  task automatic step(input int push);
    bit p;
    rempty = (level == 0);
    #1;
    p = exp_pop();
    chk("rinc", rinc, p);
    @(posedge rclk);
    model_edge();
    level = level - int'(p) + push;
    #1;
    chk("gnt", gnt, (m_owner >= 0) ? (1 << m_owner) : 0);
    chk("gnt_id", gnt_id, m_last);
    chk("busy", busy, m_owner >= 0);
    chk("burst_cnt", burst_cnt, m_pops);
    $display("t=%0t req=%b take=%b rempty=%b rinc=%b gnt=%b id=%0d busy=%b cnt=%0d",
             $time, req, take, rempty, rinc, gnt, gnt_id, busy, burst_cnt);
  endtask

  task automatic go_idle();
    req = '0;
    step(0);
    step(0);
  endtask

  initial begin
    model_reset();
    rrst = 1'b1; req = '0; take = '0; rempty = 1'b1; level = 0;
    #12;
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", burst_cnt, 0);
    chk("rst_id", gnt_id, 0);
    chk("rst_rinc", rinc, 0);
    @(posedge rclk); #1;
    rrst = 1'b0;

    // Requester 0 alone, 10 words, take high.
    req = 4'b0001; take = '1; level = 10;
    step(0);
    chk("s1_first_gnt", gnt, 4'b0001);
    for (int i = 0; i < 11; i++) step(0);

    // Two requesters alternate.
    go_idle();
    req = 4'b0101; level = 40;
    for (int i = 0; i < 16; i++) step(0);

    // Requester 2 takes on 2 of 3 cycles.
    go_idle();
    req = 4'b0100; level = 40;
    for (int i = 0; i < 10; i++) begin
      take = (i % 3 == 2) ? 4'b0000 : 4'b1111;
      step(0);
    end
    take = '1;

    // Requester 1 drops req after 2 pops.
    go_idle();
    req = 4'b0010; level = 40;
    for (int i = 0; i < 20 && !(m_owner == 1 && m_pops == 2); i++) step(0);
    chk("pre_drop_cnt", burst_cnt, 2);
    req = 4'b1101;
    step(0);
    chk("drop_gnt", gnt, 0);
    chk("drop_cnt", burst_cnt, 2);
    step(0);
    chk("after_drop_gnt", gnt, 4'b0100);

    // FIFO drains after one pop: timeout release.
    go_idle();
    req = 4'b0001; level = 1;
    for (int i = 0; i < 12; i++) step(0);
    chk("timeout_busy", busy, 0);

    // A word arriving at empty cycle 5 restarts the timeout.
    go_idle();
    req = 4'b0001; level = 1;
    for (int i = 0; i <= 12; i++) step((i == 6) ? 1 : 0);
    chk("timeout_extended", busy, 1);

    // Reset during the third pop of a burst.
    go_idle();
    go_idle();
    req = 4'b0001; level = 10;
    step(0); step(0); step(0);
    rempty = 1'b0;
    #1;
    chk("pop3_rinc", rinc, 1);
    rrst = 1'b1;
    #1;
    chk("mid_rst_rinc", rinc, 0);
    chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cnt", burst_cnt, 0);
    model_reset();
    @(posedge rclk); #1;
    rrst = 1'b0;
    req = 4'b1111; level = 10;
    step(0);
    chk("post_rst_gnt", gnt, 4'b0001);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      req  = 4'($urandom_range(0, 15));
      take = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) level = 0;
      step(($urandom_range(0, 2) == 0) ? 1 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
